// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin scheduler sharing one 32-bit UART transmitter
// Serialises whole frames from NUM_REQ requesters and recovers from a start the transmitter never takes.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int BUSY_TIMEOUT = 4,
  parameter int ID_W         = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ*32-1:0]   req_data,
  input  logic [NUM_REQ-1:0]      req_parity,
  output logic [NUM_REQ-1:0]      grant,
  output logic [NUM_REQ-1:0]      done,
  output logic                    err,
  output logic                    active,
  output logic [ID_W-1:0]         cur_id,
  output logic [31:0]             tx_data,
  output logic                    tx_start,
  output logic                    tx_parity_type,
  input  logic                    tx_busy
);

  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_ISSUE     = 2'd1;
  localparam logic [1:0] S_WAIT_BUSY = 2'd2;
  localparam logic [1:0] S_WAIT_DONE = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               err_q, err_d;
  logic               active_q, active_d;
  logic [ID_W-1:0]    cur_id_q, cur_id_d;
  logic [31:0]        tx_data_q, tx_data_d;
  logic               tx_start_q, tx_start_d;
  logic               tx_parity_q, tx_parity_d;

  logic [ID_W-1:0]    win;
  logic               win_vld;
  logic [ID_W-1:0]    ptr_inc;

  // Search downward so the candidate closest to ptr is the last one written.
  always_comb begin
    logic [ID_W-1:0] idx;
    idx     = '0;
    win     = '0;
    win_vld = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ID_W'((int'(ptr_q) + k) % NUM_REQ);
      if (req[idx]) begin
        win     = idx;
        win_vld = 1'b1;
      end
    end
  end

  assign ptr_inc = (cur_id_q == ID_W'(NUM_REQ - 1)) ? '0 : cur_id_q + ID_W'(1);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    grant_d     = '0;
    done_d      = '0;
    err_d       = 1'b0;
    active_d    = active_q;
    cur_id_d    = cur_id_q;
    tx_data_d   = tx_data_q;
    tx_start_d  = 1'b0;
    tx_parity_d = tx_parity_q;
    case (state_q)
      S_IDLE: begin
        // The cycle carrying done is a completion cycle, not an arbitration slot.
        if (win_vld && !tx_busy && (done_q == '0)) begin
          tx_data_d   = req_data[32*win +: 32];
          tx_parity_d = req_parity[win];
          cur_id_d    = win;
          grant_d     = NUM_REQ'(1) << win;
          tx_start_d  = 1'b1;
          active_d    = 1'b1;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = S_WAIT_DONE;
        end else if (cnt_q == CNT_W'(BUSY_TIMEOUT - 2)) begin
          err_d    = 1'b1;
          ptr_d    = ptr_inc;
          active_d = 1'b0;
          state_d  = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          done_d   = NUM_REQ'(1) << cur_id_q;
          ptr_d    = ptr_inc;
          active_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      grant_q     <= '0;
      done_q      <= '0;
      err_q       <= 1'b0;
      active_q    <= 1'b0;
      cur_id_q    <= '0;
      tx_data_q   <= '0;
      tx_start_q  <= 1'b0;
      tx_parity_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      err_q       <= err_d;
      active_q    <= active_d;
      cur_id_q    <= cur_id_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
      tx_parity_q <= tx_parity_d;
    end
  end

  assign grant          = grant_q;
  assign done           = done_q;
  assign err            = err_q;
  assign active         = active_q;
  assign cur_id         = cur_id_q;
  assign tx_data        = tx_data_q;
  assign tx_start       = tx_start_q;
  assign tx_parity_type = tx_parity_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed bench for uart_tx_arbiter with a small transmitter model
module tb_uart_tx_arbiter;

  localparam int NR    = 4;
  localparam int BT    = 4;
  localparam int FRAME = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    req;
  logic [127:0]  req_data;
  logic [3:0]    req_parity;
  logic [3:0]    grant;
  logic [3:0]    done;
  logic          err;
  logic          active;
  logic [1:0]    cur_id;
  logic [31:0]   tx_data;
  logic          tx_start;
  logic          tx_parity_type;
  logic          tx_busy;

  uart_tx_arbiter #(.NUM_REQ(NR), .BUSY_TIMEOUT(BT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_parity(req_parity),
    .grant(grant), .done(done), .err(err), .active(active), .cur_id(cur_id),
    .tx_data(tx_data), .tx_start(tx_start), .tx_parity_type(tx_parity_type),
    .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  logic [31:0] dat [4] = '{32'hA5A5_0F0F, 32'h1111_2222, 32'h3333_4444, 32'h5555_6666};
  logic [3:0]  par = 4'b0101;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Transmitter: busy rises two cycles after the start cycle's negedge sample, lasts FRAME cycles.
  logic model_en;
  logic pend;
  int   rem;
  initial begin
    tx_busy = 1'b0;
    pend    = 1'b0;
    rem     = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        tx_busy = 1'b0;
        pend    = 1'b0;
        rem     = 0;
      end else begin
        if (pend) begin
          tx_busy = 1'b1;
          rem     = FRAME;
        end else if (rem > 0) begin
          rem--;
          if (rem == 0) tx_busy = 1'b0;
        end
        pend = tx_start && model_en;
      end
    end
  end

  int viol = 0;
  int gcnt [4] = '{default: 0};
  int dcnt [4] = '{default: 0};
  always @(negedge clk) begin
    if (!rst) begin
      if (grant != 4'b0 && done != 4'b0) viol++;
      if (!$onehot0(grant) || !$onehot0(done)) viol++;
      for (int i = 0; i < 4; i++) begin
        if (grant[i]) gcnt[i]++;
        if (done[i]) dcnt[i]++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input string tag, output int cyc);
    cyc = 0;
    while (grant == 4'b0 && cyc < 50) begin
      tick();
      cyc++;
    end
    if (grant == 4'b0) check({tag, " grant timeout"}, 64'(0), 64'(1));
  endtask

  task automatic wait_busy(input string tag);
    int c = 0;
    while (!tx_busy && c < 20) begin
      tick();
      c++;
    end
    if (!tx_busy) check({tag, " busy timeout"}, 64'(0), 64'(1));
  endtask

  task automatic wait_frame_end(input string tag);
    int   c    = 0;
    logic seen = 1'b0;
    while ((!seen || tx_busy) && c < 60) begin
      tick();
      c++;
      if (tx_busy) seen = 1'b1;
    end
    if (c >= 60) check({tag, " frame timeout"}, 64'(0), 64'(1));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " grant"},  64'(grant),          64'(0));
    check({tag, " done"},   64'(done),           64'(0));
    check({tag, " err"},    64'(err),            64'(0));
    check({tag, " active"}, 64'(active),         64'(0));
    check({tag, " cur_id"}, 64'(cur_id),         64'(0));
    check({tag, " data"},   64'(tx_data),        64'(0));
    check({tag, " start"},  64'(tx_start),       64'(0));
    check({tag, " parity"}, 64'(tx_parity_type), 64'(0));
  endtask

  initial begin
    int         c;
    int         d0, g1, d1;
    logic [3:0] exp;
    logic [3:0] prevg;

    rst        = 1'b1;
    req        = 4'b0;
    req_parity = par;
    model_en   = 1'b1;
    req_data   = {dat[3], dat[2], dat[1], dat[0]};
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // single request
    req = 4'b0001;
    tick();
    check("single grant",  64'(grant),          64'(4'b0001));
    check("single start",  64'(tx_start),       64'(1));
    check("single data",   64'(tx_data),        64'(32'hA5A5_0F0F));
    check("single parity", 64'(tx_parity_type), 64'(1));
    check("single cur_id", 64'(cur_id),         64'(0));
    check("single active", 64'(active),         64'(1));
    req = 4'b0;
    tick();
    check("single grant pulse", 64'(grant),    64'(0));
    check("single start pulse", 64'(tx_start), 64'(0));
    wait_frame_end("single");
    check("single done",      64'(done),    64'(4'b0001));
    check("single done idle", 64'(active),  64'(0));
    check("single data hold", 64'(tx_data), 64'(32'hA5A5_0F0F));

    // fairness with all four requesting
    do_reset();
    req   = 4'b1111;
    prevg = 4'b0;
    for (int r = 0; r < 5; r++) begin
      exp = 4'(1 << (r % 4));
      wait_grant("fair", c);
      if (r > 0) check("fair rearb gap", 64'(c), 64'(2));
      check("fair grant order", 64'(grant), 64'(exp));
      check("fair no repeat", 64'(grant == prevg), 64'(0));
      check("fair data", 64'(tx_data), 64'(dat[r % 4]));
      check("fair parity", 64'(tx_parity_type), 64'(par[r % 4]));
      prevg = grant;
      req   = (r == 4) ? 4'b0 : (req & ~grant);
      wait_frame_end("fair");
      check("fair done", 64'(done), 64'(exp));
      if (r < 4) req = req | exp;
    end

    // wrap-around from ptr=3
    req = 4'b0100;
    wait_grant("wrap", c);
    check("wrap pre grant", 64'(grant), 64'(4'b0100));
    req = 4'b0;
    wait_frame_end("wrap");
    check("wrap pre done", 64'(done), 64'(4'b0100));
    req = 4'b1001;
    wait_grant("wrap", c);
    check("wrap first", 64'(grant), 64'(4'b1000));
    req = 4'b0001;
    wait_frame_end("wrap");
    check("wrap first done", 64'(done), 64'(4'b1000));
    wait_grant("wrap", c);
    check("wrap second", 64'(grant), 64'(4'b0001));
    req = 4'b0;
    wait_frame_end("wrap");
    check("wrap second done", 64'(done), 64'(4'b0001));

    // busy timeout
    model_en = 1'b0;
    d1  = dcnt[1];
    req = 4'b0010;
    wait_grant("tmo", c);
    check("tmo grant", 64'(grant), 64'(4'b0010));
    req = 4'b0;
    c   = 0;
    while (!err && c < 20) begin
      tick();
      c++;
    end
    check("tmo latency", 64'(c), 64'(BT));
    check("tmo err", 64'(err), 64'(1));
    check("tmo active", 64'(active), 64'(0));
    check("tmo done", 64'(done), 64'(0));
    tick();
    check("tmo err pulse", 64'(err), 64'(0));
    check("tmo no done", 64'(dcnt[1] - d1), 64'(0));
    model_en = 1'b1;
    req      = 4'b0111;
    wait_grant("tmo", c);
    check("tmo ptr advance", 64'(grant), 64'(4'b0100));
    req = 4'b0;
    wait_frame_end("tmo");
    check("tmo next done", 64'(done), 64'(4'b0100));

    // reset mid-frame
    d0  = dcnt[0];
    req = 4'b0001;
    wait_grant("rst", c);
    check("rst grant", 64'(grant), 64'(4'b0001));
    req = 4'b0;
    wait_busy("rst");
    tick();
    rst = 1'b1;
    #1;
    check_all_zero("rst mid");
    req = 4'b1100;
    tick();
    tick();
    rst = 1'b0;
    wait_grant("rst", c);
    check("rst ptr cleared", 64'(grant), 64'(4'b0100));
    check("rst abandoned", 64'(dcnt[0] - d0), 64'(0));
    req = 4'b0;
    wait_frame_end("rst");
    check("rst done", 64'(done), 64'(4'b0100));

    // withdrawn request
    g1  = gcnt[1];
    d1  = dcnt[1];
    req = 4'b0001;
    wait_grant("wdr", c);
    check("wdr grant", 64'(grant), 64'(4'b0001));
    req = 4'b0;
    wait_busy("wdr");
    req = 4'b0010;
    tick();
    req = 4'b0;
    wait_frame_end("wdr");
    check("wdr done", 64'(done), 64'(4'b0001));
    repeat (10) tick();
    check("wdr no grant1", 64'(gcnt[1] - g1), 64'(0));
    check("wdr no done1",  64'(dcnt[1] - d1), 64'(0));

    check("protocol", 64'(viol), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares one 32-bit-word UART transmitter between `NUM_REQ` requesters. It sits between the client logic and the transmitter, and drives the transmitter's `data`, `start` and `parity_type` inputs while monitoring its `busy` output. It serialises whole frames, reports per-requester acceptance and completion, and recovers if the transmitter fails to accept a start.

## Interface
- `NUM_REQ`, default 4: number of requesters; must be ≥ 2.
- `BUSY_TIMEOUT`, default 4: maximum cycles to wait for `tx_busy` to rise after `tx_start`; must be ≥ 2.
- `ID_W`, default `$clog2(NUM_REQ)`: width of `cur_id`.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset; asynchronous, active-high.
- `req` in NUM_REQ: per-requester request level; held high until `grant`.
- `req_data` in NUM_REQ*32: word for requester i at `[32*i+31:32*i]`; stable while `req[i]` is high.
- `req_parity` in NUM_REQ: per-requester parity type (1 = odd, 0 = even, as the transmitter defines it).
- `grant` out NUM_REQ: one-hot pulse of 1 cycle; the word has been captured.
- `done` out NUM_REQ: one-hot pulse of 1 cycle; the frame for that requester has finished.
- `err` out 1: 1-cycle pulse on busy timeout.
- `active` out 1: high from arbitration until return to IDLE.
- `cur_id` out ID_W: index of the requester being served.
- `tx_data` out 32: connects to the transmitter's `data`.
- `tx_start` out 1: connects to the transmitter's `start`.
- `tx_parity_type` out 1: connects to the transmitter's `parity_type`.
- `tx_busy` in 1: from the transmitter's `busy`.

## Operation
- **States:** IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- **Round-robin pointer `ptr`:** reset value 0.
  - The winner is the first set bit of `req` when searching from `ptr` upward, wrapping modulo NUM_REQ.
- **IDLE:**
  - Arbitration happens only when `|req` is true and `tx_busy` is 0.
  - On arbitration, register the following, then go to ISSUE:
    - `tx_data` ← winner's `req_data`
    - `tx_parity_type` ← `req_parity[winner]`
    - `cur_id` ← winner
    - `grant` ← onehot(winner)
    - `tx_start` ← 1
    - `active` ← 1
- **ISSUE:**
  - This is the only cycle in which `grant` and `tx_start` are high; both clear on exit.
  - Load the timeout counter with 0, then go to WAIT_BUSY.
  - After `grant`, the requester may change its data or drop its request.
- **WAIT_BUSY:**
  - If `tx_busy` = 1, go to WAIT_DONE.
  - Otherwise increment the counter. When the counter reaches `BUSY_TIMEOUT`-1 with `tx_busy` still 0:
    - pulse `err`
    - pulse no `done`
    - set `ptr` ← `cur_id`+1 (mod NUM_REQ)
    - go to IDLE and clear `active`
- **WAIT_DONE:**
  - When `tx_busy` = 0, pulse `done[cur_id]`, set `ptr` ← `cur_id`+1 (mod NUM_REQ), clear `active`, and go to IDLE.
- **Data hold:** `tx_data`, `tx_parity_type` and `cur_id` hold their values until the next arbitration.
- **Withdrawn request:** a request dropped before it is granted is simply not considered; no `grant` is issued for it.
- **Reset:** at any time, reset forces IDLE, clears `ptr`, and drives every output to its reset value.
  - Outputs reset to 0: `grant`, `done`, `err`, `active`, `cur_id`, `tx_data`, `tx_start`, `tx_parity_type`.
  - Any in-flight frame is abandoned without a `done` pulse.
  - The transmitter shares `rst` and aborts at the same time.

## Timing
- All outputs are registered.
- Arbitration in IDLE at cycle N gives `grant` and `tx_start` high in cycle N+1.
- The transmitter captures the word at the end of N+1, and `tx_busy` is high from N+2. WAIT_BUSY therefore normally exits after 1 cycle.
- `done` is high in the cycle after the first cycle in which `tx_busy` is sampled low in WAIT_DONE.
- With a continuously pending request, the next arbitration occurs 1 cycle after the `done` cycle, i.e. in IDLE, provided `tx_busy` is 0.
- Simultaneous events:
  - A `req` rising in the same cycle as `done` is seen at the following IDLE evaluation.
  - When the pointer update and arbitration would coincide, `ptr` is updated first: arbitration always uses the post-completion pointer.
- `grant` and `done` are never high in the same cycle; at most one bit of each is set.
- At most one frame is outstanding at any time.

## Test plan
- **Single request:** `req`=0001, data 0xA5A5_0F0F, parity 1 → `grant`=0001 and `tx_start` pulse 1 cycle after request; `tx_data`=0xA5A5_0F0F; `tx_parity_type`=1; `done`=0001 1 cycle after `tx_busy` falls.
- **Fairness:** `req`=1111 held, with each requester re-asserting after `done` → grant order 0001, 0010, 0100, 1000, 0001; no requester is granted twice in a row.
- **Wrap-around:** `ptr`=3 (after serving requester 2), `req`=1001 → grant 1000 first, then 0001.
- **Busy timeout:** `tx_busy` tied 0, `req`=0010 → `err` pulse exactly `BUSY_TIMEOUT` cycles after `tx_start`, no `done`, `active` low, `ptr`=2.
- **Reset mid-frame:** `rst` asserted while in WAIT_DONE → all outputs 0 immediately; after release, a pending `req`=0100 is granted 0100 (the search starts from `ptr`=0).
- **Withdrawn request:** `req[1]` pulsed high and then dropped while requester 0 is being served → no `grant[1]` and no `done[1]` ever.
